// File: rtl/jtkcpu_stack_if.sv
// Memory-bus and register-file side of the JTKCPU stack sequencer.
// The master is the sequencer; the slave side is the bus/regfile glue.
interface jtkcpu_stack_if #(
    parameter int NREG = 8,
    parameter int AW   = 16
);
    logic            bus_req;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [7:0]      bus_dout;
    logic [7:0]      bus_din;
    logic            bus_ack;
    logic [NREG-1:0] reg_sel;
    logic            reg_hi;
    logic [7:0]      reg_rd;
    logic            reg_wr;
    logic [7:0]      reg_wdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_dout,
        output reg_sel, reg_hi, reg_wr, reg_wdata,
        input  bus_din, bus_ack, reg_rd
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_dout,
        input  reg_sel, reg_hi, reg_wr, reg_wdata,
        output bus_din, bus_ack, reg_rd
    );
endinterface

// File: rtl/jtkcpu_stack.sv
// JTKCPU push/pull sequencer: walks a slot mask one byte per bus
// transfer and reports the final stack pointer.
module jtkcpu_stack #(
    parameter int              NREG = 8,
    parameter int              AW   = 16,
    parameter logic [NREG-1:0] WIDE = 'hF0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            start,
    input  logic            pull,
    input  logic [NREG-1:0] mask,
    input  logic [AW-1:0]   sp,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   sp_out,
    jtkcpu_stack_if.master  bus
);
    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_pull;
    logic            r_second;
    logic [NREG-1:0] r_mask;
    logic [AW-1:0]   r_ptr;

    logic [SW-1:0]   w_slot;
    logic [NREG-1:0] w_onehot;
    logic [NREG-1:0] w_rest;
    logic            w_wide;
    logic            w_hi;
    logic            w_end;
    logic            w_xfer;
    logic            w_fire;
    logic            w_last;

    // push takes the highest set slot, pull the lowest
    always_comb begin
        w_slot = '0;
        if (r_pull) begin
            for (int i = NREG - 1; i >= 0; i--)
                if (r_mask[i]) w_slot = SW'(i);
        end else begin
            for (int i = 0; i < NREG; i++)
                if (r_mask[i]) w_slot = SW'(i);
        end
    end

    always_comb begin
        w_onehot = '0;
        w_onehot[w_slot] = 1'b1;
    end

    assign w_wide = WIDE[w_slot];
    // push sends low then high; pull sends high then low
    assign w_hi   = w_wide & (r_pull ^ r_second);
    assign w_end  = ~w_wide | r_second;
    assign w_xfer = (r_state == XFER);
    assign w_fire = cen & w_xfer & bus.bus_ack;
    assign w_rest = r_mask & ~w_onehot;
    assign w_last = w_end & (w_rest == '0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = (mask != '0) ? XFER : DONE;
            XFER: if (bus.bus_ack && w_last) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else if (cen)
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pull   <= 1'b0;
            r_second <= 1'b0;
            r_mask   <= '0;
            r_ptr    <= '0;
        end else if (cen) begin
            if (r_state == IDLE && start) begin
                r_pull   <= pull;
                r_mask   <= mask;
                r_ptr    <= sp;
                r_second <= 1'b0;
            end else if (w_fire) begin
                r_ptr <= r_pull ? r_ptr + AW'(1) : r_ptr - AW'(1);
                if (w_end) begin
                    r_mask   <= w_rest;
                    r_second <= 1'b0;
                end else begin
                    r_second <= 1'b1;
                end
            end
        end
    end

    assign busy          = w_xfer;
    assign done          = (r_state == DONE);
    assign sp_out        = r_ptr;
    assign bus.bus_req   = w_xfer;
    assign bus.bus_we    = w_xfer & ~r_pull;
    assign bus.bus_addr  = !w_xfer ? '0 :
                           r_pull  ? r_ptr : r_ptr - AW'(1);
    assign bus.bus_dout  = bus.reg_rd;
    assign bus.reg_sel   = w_xfer ? w_onehot : '0;
    assign bus.reg_hi    = w_xfer & w_hi;
    assign bus.reg_wr    = w_fire & r_pull;
    assign bus.reg_wdata = bus.bus_din;
endmodule

// File: doc/jtkcpu_stack.md
# jtkcpu_stack

Parametrised push/pull sequencer for the JTKCPU stack path. It walks a register-select mask one byte per bus transfer and drives a request/acknowledge memory handshake. It supplies per-byte slot/half selects to the register file and returns the final stack pointer. It sits between the instruction sequencer (start/mask/sp) and the memory bus arbiter, replacing the ad-hoc per-bit push/pull stepping inside the register file.

## Interface

Parameters:
- NREG, 8, number of register slots (mask width); slot NREG-1 is pushed first.
- AW, 16, stack pointer / bus address width.
- WIDE, 8'hF0, per-slot width mask; bit i set means slot i is 16-bit (two bytes), else 8-bit.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cen  in  1  clock enable; all state advances only on cycles with cen=1.
- start  in  1  begin operation; honoured only in IDLE.
- pull  in  1  1 = pull, 0 = push; sampled with start.
- mask  in  NREG  slots to transfer; sampled with start.
- sp  in  AW  stack pointer start value; sampled with start.
- busy  out  1  high from the cen cycle after start until done.
- done  out  1  one-cen-cycle pulse at end of operation.
- sp_out  out  AW  final stack pointer, valid from done onward.
- bus_req  out  1  transfer request.
- bus_we  out  1  1 on push transfers.
- bus_addr  out  AW  transfer address.
- bus_dout  out  8  push data, equal to reg_rd.
- bus_din  in  8  pull data.
- bus_ack  in  1  transfer completes on a cen cycle with bus_req && bus_ack.
- reg_sel  out  NREG  one-hot slot of the current byte; 0 when idle.
- reg_hi  out  1  current byte is the high half of a wide slot.
- reg_rd  in  8  register-file byte for reg_sel/reg_hi; combinational.
- reg_wr  out  1  pull write strobe: pull && bus_req && bus_ack && cen.
- reg_wdata  out  8  equals bus_din.

## Operation

- States: IDLE, XFER, DONE.
- IDLE + start:
  - Latch pull, mask and sp into working copies.
  - If mask!=0, go to XFER; else go to DONE with zero transfers.
- Push order:
  - Slots are taken highest index first.
  - For wide slots, the low byte goes before the high byte.
  - Addressing is pre-decrement: each byte is written at ptr-1, and ptr becomes ptr-1 on ack.
- Pull order:
  - Slots are taken lowest index first.
  - For wide slots, the high byte goes before the low byte.
  - Addressing is post-increment: each byte is read at ptr, and ptr becomes ptr+1 on ack.
- Address arithmetic is modulo 2^AW. Wrap-around is silent: push at 0 writes address 2^AW-1.
- XFER:
  - bus_req=1. bus_addr, bus_we, reg_sel and reg_hi stay stable until ack.
  - On ack, clear the mask bit once the slot's last byte is transferred, then advance to the next byte.
  - After the ack of the last byte, go to DONE.
- DONE:
  - done=1, busy=0, bus_req=0, sp_out=ptr.
  - Next cen cycle returns to IDLE; a start in this cycle is ignored.
- start while busy: ignored, and the working copies are unchanged.
- cen=0 freezes all state. Outputs hold; reg_wr=0.
- Reset values:
  - State IDLE.
  - busy=0, done=0, bus_req=0, bus_we=0, bus_addr=0, reg_sel=0, reg_hi=0, sp_out=0.
  - reg_wr=0; bus_dout and reg_wdata are pass-through.
- Reset mid-operation: everything returns to IDLE immediately. No done pulse; sp_out=0.

## Timing

- Start sampled on cen cycle T0; bus_req is high from T1.
- With bus_ack tied high, N bytes occupy cycles T1..TN back to back. done is at TN+1, and IDLE at TN+2.
- mask=0: done at T1, bus_req never asserted, sp_out=sp.
- Each wait-state cycle (bus_ack=0) adds one cycle. No byte is skipped or repeated.
- Bytes per operation = popcount(mask) + popcount(mask & WIDE).
- The register file sees reg_wr in the same cycle as the ack, with reg_sel/reg_hi naming the byte being written.

## Test plan

- Push: WIDE=8'hF0, sp=0x1000, mask=0x81, ack tied 1.
  - Writes: 0x0FFF slot7 low, 0x0FFE slot7 high, 0x0FFD slot0.
  - done at T4, sp_out=0x0FFD.
- Pull: sp=0x0FFD, mask=0x81, bus_din sequence 0x11/0x22/0x33.
  - reg_wr with slot0=0x11 @0x0FFD, slot7 hi=0x22 @0x0FFE, slot7 lo=0x33 @0x0FFF.
  - sp_out=0x1000.
- mask=0x00: done exactly one cen cycle after start, no bus_req, sp_out=sp.
- Wait states: ack low for 3 cycles on the first byte.
  - bus_addr/reg_sel held constant.
  - done delayed by exactly 3 cycles.
  - A cen=0 gap also holds all outputs.
- Wrap: push sp=0x0000, mask=0x01 → write @0xFFFF, sp_out=0xFFFF. Pull sp=0xFFFF, mask=0x10 → reads 0xFFFF then 0x0000, sp_out=0x0001.
- Reset mid-XFER plus start during busy:
  - rst asserted mid-transfer → bus_req=0 and busy=0 immediately, no done.
  - start pulsed while busy is ignored, and the byte count of the running operation is unchanged.
